// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module  : alu_unit
// Brief   : RV32I register-register ALU, one-cycle registered result.
// Revision: 1.0
// ============================================================================
module alu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] aluin1,
  input  logic [XLEN-1:0] aluin2,
  input  logic [2:0]      funct3,
  input  logic            funct7,
  output logic [XLEN-1:0] aluout
);

  localparam int c_SHW = $clog2(XLEN);

  logic [c_SHW-1:0]       w_shamt;
  logic signed [XLEN-1:0] w_a_signed;
  logic signed [XLEN-1:0] w_b_signed;
  logic [XLEN-1:0]        w_result;
  logic [XLEN-1:0]        r_aluout;

  assign w_shamt    = aluin2[c_SHW-1:0];
  assign w_a_signed = aluin1;
  assign w_b_signed = aluin2;

  // Unknown select values fall to the zero default branches, so X never reaches the register.
  always_comb begin
    w_result = '0;
    case (funct3)
      3'b000: begin
        case (funct7)
          1'b0:    w_result = aluin1 + aluin2;
          1'b1:    w_result = aluin1 - aluin2;
          default: w_result = '0;
        endcase
      end
      3'b001:  w_result = aluin1 << w_shamt;
      3'b010:  w_result = {{(XLEN-1){1'b0}}, (w_a_signed < w_b_signed)};
      3'b011:  w_result = {{(XLEN-1){1'b0}}, (aluin1 < aluin2)};
      3'b100:  w_result = aluin1 ^ aluin2;
      3'b101: begin
        case (funct7)
          1'b0:    w_result = aluin1 >> w_shamt;
          1'b1:    w_result = w_a_signed >>> w_shamt;
          default: w_result = '0;
        endcase
      end
      3'b110:  w_result = aluin1 | aluin2;
      3'b111:  w_result = aluin1 & aluin2;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aluout <= '0;
    end else begin
      r_aluout <= w_result;
    end
  end

  assign aluout = r_aluout;

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_unit
// Brief   : Directed vector table plus randomized checks against a reference model.
// Revision: 1.0
// ============================================================================
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] aluin1;
  logic [31:0] aluin2;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] aluout;

  int total;
  int bad;

  alu_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .aluin1 (aluin1),
    .aluin2 (aluin2),
    .funct3 (funct3),
    .funct7 (funct7),
    .aluout (aluout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference: each operation from its arithmetic definition, not from shift/compare primitives.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic f7);
    int unsigned s;
    logic [63:0] prod;
    logic [31:0] q;
    logic [32:0] sum;
    s = int'(b % 32);
    case (f3)
      3'd0: begin
        if (f7) sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        else    sum = {1'b0, a} + {1'b0, b};
        return sum[31:0];
      end
      3'd1: begin
        prod = {32'd0, a} * (64'd1 << s);
        return prod[31:0];
      end
      3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        q = a / (32'd1 << s);
        if (f7 && a[31]) q = q | ~(32'hFFFF_FFFF >> s);
        return q;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3, input logic f7);
    @(negedge clk);
    aluin1 = a;
    aluin2 = b;
    funct3 = f3;
    funct7 = f7;
  endtask

  task automatic add_vec(input string n, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic f7, input logic [31:0] e);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.f3 = f3; v.f7 = f7; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] prev_exp;
    logic [31:0] exp;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        f7;

    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    aluin1 = '0;
    aluin2 = '0;
    funct3 = '0;
    funct7 = 1'b0;

    add_vec("add",        32'h7,         32'hA,         3'b000, 1'b0, 32'h0000_0011);
    add_vec("sub",        32'h7,         32'hA,         3'b000, 1'b1, 32'hFFFF_FFFD);
    add_vec("sll",        32'h7,         32'hA,         3'b001, 1'b0, 32'h0000_1C00);
    add_vec("xor",        32'h7,         32'hA,         3'b100, 1'b0, 32'h0000_000D);
    add_vec("or",         32'h7,         32'hA,         3'b110, 1'b0, 32'h0000_000F);
    add_vec("and",        32'h7,         32'hA,         3'b111, 1'b0, 32'h0000_0002);
    add_vec("srl_neg",    32'h8000_0007, 32'h8000_000A, 3'b101, 1'b0, 32'h0020_0000);
    add_vec("sra_neg",    32'h8000_0007, 32'h8000_000A, 3'b101, 1'b1, 32'hFFE0_0000);
    add_vec("slt_neg",    32'h8000_0007, 32'h8000_000A, 3'b010, 1'b0, 32'h0000_0001);
    add_vec("sltu_big",   32'h8000_0007, 32'h8000_000A, 3'b011, 1'b0, 32'h0000_0001);
    add_vec("slt_mixed",  32'h7,         32'h8000_000A, 3'b010, 1'b0, 32'h0000_0000);
    add_vec("sltu_mixed", 32'h7,         32'h8000_000A, 3'b011, 1'b0, 32'h0000_0001);
    add_vec("sll_by0",    32'h7,         32'h20,        3'b001, 1'b0, 32'h0000_0007);
    add_vec("srl_by0",    32'h7,         32'h20,        3'b101, 1'b0, 32'h0000_0007);
    add_vec("sra_by0",    32'h7,         32'h20,        3'b101, 1'b1, 32'h0000_0007);
    add_vec("or_f7",      32'h7,         32'hA,         3'b110, 1'b1, 32'h0000_000F);
    add_vec("xor_f7",     32'h7,         32'hA,         3'b100, 1'b1, 32'h0000_000D);
    add_vec("sll_f7",     32'h7,         32'hA,         3'b001, 1'b1, 32'h0000_1C00);
    add_vec("funct3_x",   32'h0,         32'h0,         3'bxxx, 1'b0, 32'h0000_0000);

    repeat (2) @(posedge clk);
    #1 check("reset_state", aluout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, back-to-back: each result checked one edge after it was driven.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].f7);
      @(posedge clk);
      #1 check(vecs[i].name, aluout, vecs[i].exp);
    end

    // Asynchronous reset mid-cycle with a nonzero result held.
    drive(32'h1234_0000, 32'h0000_5678, 3'b110, 1'b0);
    @(posedge clk);
    #1 check("pre_reset", aluout, 32'h1234_5678);
    #2 rst_n = 1'b0;
    #1 check("async_reset", aluout, 32'h0);
    @(posedge clk);
    #1 check("reset_hold", aluout, 32'h0);
    drive(32'h7, 32'hA, 3'b000, 1'b0);
    rst_n = 1'b1;
    #1 check("post_release_hold", aluout, 32'h0);
    @(posedge clk);
    #1 check("add_after_reset", aluout, 32'h0000_0011);

    // Randomized back-to-back ops; before each edge the previous result must still be held.
    prev_exp = 32'h0000_0011;
    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000 | a;
      exp = ref_alu(a, b, f3, f7);
      drive(a, b, f3, f7);
      #1 check("rand_hold", aluout, prev_exp);
      @(posedge clk);
      #1 check("rand_op", aluout, exp);
      prev_exp = exp;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
